// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default widths, the "no producer" label and the
// functional-unit source indices used by the arbiter and reservation stations.
package cdb_arbiter_pkg;

  localparam int unsigned N_SRC_DEF  = 3;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned TAG_W_DEF  = 5;

  // Label 0 marks "no producer"; such results are accepted and dropped.
  localparam int unsigned NO_TAG = 0;

  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_MUL = 1;
  localparam int unsigned SRC_LD  = 2;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way combinational round-robin arbiter: the first set request at or after
// ptr (wrapping) receives the one-hot grant.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N = N_SRC_DEF
) (
  input  logic [N-1:0]        req,
  input  logic [ptr_w(N)-1:0] ptr,
  output logic [N-1:0]        grant
);

  logic [31:0] pos;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && (pos == i) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus scheduler: one-entry holding buffer per producer, round-robin
// selection among full buffers, registered single-driver CDB broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC  = N_SRC_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        req_valid,
  output logic [N_SRC-1:0]        req_ready,
  input  logic [N_SRC*DATA_W-1:0] req_data,
  input  logic [N_SRC*TAG_W-1:0]  req_label,
  output logic                    cdb_valid,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [TAG_W-1:0]        cdb_label,
  output logic [N_SRC-1:0]        cdb_grant
);

  localparam int unsigned PTR_W = ptr_w(N_SRC);

  buf_state_e        state_q   [N_SRC];
  buf_state_e        state_d   [N_SRC];
  logic [DATA_W-1:0] buf_data  [N_SRC];
  logic [TAG_W-1:0]  buf_label [N_SRC];

  logic [N_SRC-1:0]  full;
  logic [N_SRC-1:0]  arb_grant;
  logic [N_SRC-1:0]  grant_now;
  logic [N_SRC-1:0]  accept;
  logic [N_SRC-1:0]  keep;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic [DATA_W-1:0] sel_data;
  logic [TAG_W-1:0]  sel_label;

  always_comb begin
    full = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      full[i] = (state_q[i] == BUF_FULL);
    end
  end

  rr_arbiter #(
    .N (N_SRC)
  ) u_rr (
    .req   (full),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  // Flush suppresses the grant as well, so the pointer and outputs see no winner.
  assign grant_now = flush ? '0 : arb_grant;
  assign req_ready = flush ? '0 : (~full | grant_now);
  assign accept    = req_valid & req_ready;

  always_comb begin
    keep      = '0;
    rr_ptr_d  = rr_ptr;
    sel_data  = '0;
    sel_label = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      keep[i]    = accept[i] && (req_label[i*TAG_W +: TAG_W] != TAG_W'(NO_TAG));
      state_d[i] = state_q[i];
      if (flush) begin
        state_d[i] = BUF_EMPTY;
      end else if (accept[i]) begin
        state_d[i] = keep[i] ? BUF_FULL : BUF_EMPTY;
      end else if (grant_now[i]) begin
        state_d[i] = BUF_EMPTY;
      end
      if (grant_now[i]) begin
        sel_data  = sel_data  | buf_data[i];
        sel_label = sel_label | buf_label[i];
        rr_ptr_d  = (i + 1 == N_SRC) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        state_q[i] <= BUF_EMPTY;
      end
      rr_ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        state_q[i] <= state_d[i];
      end
      rr_ptr <= rr_ptr_d;
    end
  end

  // Payload is only meaningful while the buffer is FULL, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (keep[i]) begin
        buf_data[i]  <= req_data[i*DATA_W +: DATA_W];
        buf_label[i] <= req_label[i*TAG_W +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_label <= '0;
      cdb_grant <= '0;
    end else begin
      cdb_valid <= |grant_now;
      cdb_grant <= grant_now;
      if (|grant_now) begin
        cdb_data  <= sel_data;
        cdb_label <= sel_label;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised and directed bench for cdb_arbiter: a slot-level reference model
// predicts broadcasts into a queue that a negedge monitor drains and compares.
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [N*TW-1:0] req_label = '0;
  logic            cdb_valid;
  logic [DW-1:0]   cdb_data;
  logic [TW-1:0]   cdb_label;
  logic [N-1:0]    cdb_grant;

  cdb_arbiter #(
    .N_SRC  (N),
    .DATA_W (DW),
    .TAG_W  (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_label (req_label),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_label (cdb_label),
    .cdb_grant (cdb_grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int            at;
    logic [DW-1:0] d;
    logic [TW-1:0] l;
    logic [N-1:0]  g;
  } exp_t;

  exp_t expq[$];

  // reference model: one optional result per source plus a rotating start index
  bit            m_full  [N];
  logic [DW-1:0] m_data  [N];
  logic [TW-1:0] m_label [N];
  int            m_ptr;

  logic [N-1:0]  drv_v;
  logic [DW-1:0] drv_d [N];
  logic [TW-1:0] drv_l [N];
  logic          drv_flush;

  bit   mon_en = 1'b0;
  bit   ev;
  exp_t e;

  always @(negedge clk) begin
    if (mon_en) begin
      ev = (expq.size() > 0) && (expq[0].at == cyc);
      chk("cdb_valid", 64'(cdb_valid), 64'(ev));
      if (ev) begin
        e = expq.pop_front();
        chk("cdb_data",  64'(cdb_data),  64'(e.d));
        chk("cdb_label", 64'(cdb_label), 64'(e.l));
        chk("cdb_grant", 64'(cdb_grant), 64'(e.g));
      end else begin
        chk("cdb_grant_idle", 64'(cdb_grant), 64'(0));
      end
    end
  end

  task automatic put(input int i, input logic [DW-1:0] d, input logic [TW-1:0] l);
    drv_v[i] = 1'b1;
    drv_d[i] = d;
    drv_l[i] = l;
  endtask

  task automatic idle();
    drv_v     = '0;
    drv_flush = 1'b0;
  endtask

  task automatic cycle();
    int g;
    int j;
    logic [N-1:0] exp_ready;
    exp_t x;
    @(negedge clk);
    #1;
    req_valid = drv_v;
    flush     = drv_flush;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW]  = drv_d[i];
      req_label[i*TW +: TW] = drv_l[i];
    end
    #1;
    g = -1;
    if (!drv_flush) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && m_full[j]) g = j;
      end
    end
    for (int i = 0; i < N; i++) exp_ready[i] = !drv_flush && (!m_full[i] || i == g);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) begin
      x.at = cyc + 1;
      x.d  = m_data[g];
      x.l  = m_label[g];
      x.g  = N'(1 << g);
      expq.push_back(x);
      m_full[g] = 1'b0;
      m_ptr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (drv_flush) m_full[i] = 1'b0;
      else if (drv_v[i] && exp_ready[i] && drv_l[i] != 0) begin
        m_full[i]  = 1'b1;
        m_data[i]  = drv_d[i];
        m_label[i] = drv_l[i];
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    flush     = 1'b0;
    idle();
    for (int i = 0; i < N; i++) m_full[i] = 1'b0;
    m_ptr = 0;
    expq.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(cdb_valid), 64'(0));
    chk("rst_data",  64'(cdb_data),  64'(0));
    chk("rst_label", 64'(cdb_label), 64'(0));
    chk("rst_grant", 64'(cdb_grant), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'({N{1'b1}}));
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      drv_d[i] = '0;
      drv_l[i] = '0;
    end
    idle();
    do_reset();
    mon_en = 1'b1;

    // single ALU result
    put(0, 32'h0000_00AA, 5'd3);
    cycle();
    idle_cycles(4);

    // three-way contention from rr_ptr=0, then a 0/1 pair to probe the pointer
    do_reset();
    put(0, 32'h1111_0001, 5'd1);
    put(1, 32'h2222_0002, 5'd2);
    put(2, 32'h3333_0003, 5'd3);
    cycle();
    idle_cycles(4);
    put(1, 32'h0000_0B0B, 5'd9);
    put(0, 32'h0000_0A0A, 5'd8);
    cycle();
    idle_cycles(4);

    // back-to-back streaming on source 1
    for (int k = 0; k < 8; k++) begin
      idle();
      put(1, 32'hC0DE_0000 + 32'(k), TW'(4 + k));
      cycle();
    end
    idle_cycles(3);

    // saturation on sources 0 and 2
    for (int k = 0; k < 20; k++) begin
      idle();
      put(0, $urandom, TW'($urandom_range(1, 31)));
      put(2, $urandom, TW'($urandom_range(1, 31)));
      cycle();
    end
    idle_cycles(4);

    // flush with two buffered results
    put(0, 32'h0000_0555, 5'd5);
    put(1, 32'h0000_0666, 5'd6);
    cycle();
    idle();
    drv_flush = 1'b1;
    cycle();
    idle_cycles(4);

    // label 0 is accepted and dropped
    put(2, 32'hDEAD_BEEF, 5'd0);
    cycle();
    idle_cycles(3);

    // reset while label 7 is on the bus; label 8 is also lost
    put(0, 32'h0000_0777, 5'd7);
    put(1, 32'h0000_0888, 5'd8);
    cycle();
    idle();
    cycle();
    do_reset();
    idle_cycles(4);

    // random traffic with occasional flushes and dropped labels
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        drv_v[i] = ($urandom_range(0, 99) < 60);
        drv_d[i] = $urandom;
        drv_l[i] = ($urandom_range(0, 9) == 0) ? '0 : TW'($urandom_range(1, 31));
      end
      drv_flush = ($urandom_range(0, 49) == 0);
      cycle();
    end
    idle_cycles(5);

    chk("queue_drained", 64'(expq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
